// File: rtl/work_dispatcher.sv
// ---------------------------------------------------------------------------
// work_dispatcher
//
// Dynamic work scheduler for the multicore prime-search array. Cores ask for
// chunks of the number range on demand. A round-robin arbiter hands out at
// most one chunk per cycle. Once the range is used up, each further request
// is answered with grant_last, and that core is marked as retired. The block
// also adds up the prime counts reported by the cores. It counts the cycles
// from start until every core has retired.
//
// Ports:
//   clk           system clock (divided clock)
//   reset         asynchronous, active-low reset
//   start         one-cycle pulse, begins a run from IDLE or DONE
//   req           per-core work request, held until granted
//   grant         one-hot, one-cycle grant pulse (registered)
//   grant_last    qualifies grant: no work left, core must halt
//   chunk_lo/hi   inclusive bounds of the granted chunk, valid with grant
//   res_valid     per-core one-cycle result strobe
//   res_data      per-core prime count, core i at bits [8i+7:8i]
//   total_primes  saturating sum of all accepted results
//   clk_cycles    saturating count of cycles spent in DISPATCH/DRAIN
//   busy          high in DISPATCH or DRAIN
//   done          high in DONE
//   retired       cores that have received grant_last
// ---------------------------------------------------------------------------
module work_dispatcher #(
   parameter int         CORES    = 4,
   parameter int         CHUNK    = 16,
   parameter logic [7:0] RANGE_LO = 8'd0,
   parameter logic [7:0] RANGE_HI = 8'd255
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [CORES-1:0]   req,
   output logic [CORES-1:0]   grant,
   output logic               grant_last,
   output logic [7:0]         chunk_lo,
   output logic [7:0]         chunk_hi,
   input  logic [CORES-1:0]   res_valid,
   input  logic [8*CORES-1:0] res_data,
   output logic [15:0]        total_primes,
   output logic [15:0]        clk_cycles,
   output logic               busy,
   output logic               done,
   output logic [CORES-1:0]   retired
);

   localparam int PTR_W = (CORES > 1) ? $clog2(CORES) : 1;

   typedef enum logic [1:0] {IDLE, DISPATCH, DRAIN, DONE} state_t;

   state_t           r_state;
   state_t           w_nextState;
   logic [8:0]       r_nextBase;
   logic [PTR_W-1:0] r_rrPtr;
   logic [CORES-1:0] r_grant;
   logic             r_grantLast;
   logic [7:0]       r_chunkLo;
   logic [7:0]       r_chunkHi;
   logic [15:0]      r_total;
   logic [15:0]      r_cycles;
   logic [CORES-1:0] r_retired;

   logic             w_active;
   logic             w_startRun;
   logic             w_exhausted;
   logic [CORES-1:0] w_eligible;
   logic             w_found;
   int               w_idx;
   int               w_winIdx;
   logic [CORES-1:0] w_winOneHot;
   logic [9:0]       w_chunkEnd;
   logic [7:0]       w_chunkHi;
   logic [11:0]      w_resSum;
   logic [16:0]      w_totalSum;

   // Common run-control terms. The next_base register is 9 bits wide, so it
   // can step past RANGE_HI without wrapping. "Exhausted" is therefore a
   // plain magnitude compare. A core granted last cycle is masked out, and
   // so is a core that has already retired. This keeps a held req from
   // being granted twice.
   always_comb begin
      w_active    = (r_state == DISPATCH) || (r_state == DRAIN);
      w_startRun  = start && ((r_state == IDLE) || (r_state == DONE));
      w_exhausted = r_nextBase > {1'b0, RANGE_HI};
      w_eligible  = req & ~r_retired & ~r_grant;
      w_chunkEnd  = {1'b0, r_nextBase} + 10'(CHUNK - 1);
      w_chunkHi   = (w_chunkEnd > {2'b00, RANGE_HI}) ? RANGE_HI : w_chunkEnd[7:0];
   end

   // Round-robin search. Scan CORES positions, starting at the pointer and
   // wrapping around. The first eligible request found wins.
   always_comb begin
      w_found     = 1'b0;
      w_winIdx    = 0;
      w_idx       = 0;
      w_winOneHot = '0;
      for (int k = 0; k < CORES; k++) begin
         w_idx = (int'(r_rrPtr) + k) % CORES;
         if (!w_found && w_eligible[w_idx]) begin
            w_found  = 1'b1;
            w_winIdx = w_idx;
         end
      end
      if (w_found) begin
         w_winOneHot = CORES'(1) << w_winIdx;
      end
   end

   // Add up every result strobe raised in this cycle. The running total
   // is widened by one bit so that saturation only needs a carry check.
   always_comb begin
      w_resSum = '0;
      for (int i = 0; i < CORES; i++) begin
         if (res_valid[i]) begin
            w_resSum = w_resSum + 12'(res_data[8*i +: 8]);
         end
      end
      w_totalSum = 17'(r_total) + 17'(w_resSum);
   end

   // Next-state logic and state-decoded status outputs. DISPATCH moves to
   // DRAIN once the range is used up. DRAIN moves to DONE once the retired
   // register is full. Because retired is a register, DONE arrives one
   // cycle after the final grant_last.
   always_comb begin
      w_nextState = r_state;
      busy        = 1'b0;
      done        = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) w_nextState = DISPATCH;
         end
         DISPATCH: begin
            busy = 1'b1;
            if (w_exhausted) w_nextState = DRAIN;
         end
         DRAIN: begin
            busy = 1'b1;
            if (&r_retired) w_nextState = DONE;
         end
         DONE: begin
            done = 1'b1;
            if (start) w_nextState = DISPATCH;
         end
         default: w_nextState = IDLE;
      endcase
   end

   // State register and datapath. A start pulse re-initialises the run.
   // While the run is active, each cycle may issue one grant, absorb the
   // results, and advance the cycle counter. The grant is a one-cycle
   // pulse. chunk_lo and chunk_hi keep their last values until the next
   // grant.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= IDLE;
         r_nextBase  <= {1'b0, RANGE_LO};
         r_rrPtr     <= '0;
         r_grant     <= '0;
         r_grantLast <= 1'b0;
         r_chunkLo   <= '0;
         r_chunkHi   <= '0;
         r_total     <= '0;
         r_cycles    <= '0;
         r_retired   <= '0;
      end else begin
         r_state     <= w_nextState;
         r_grant     <= '0;
         r_grantLast <= 1'b0;
         if (w_startRun) begin
            r_nextBase <= {1'b0, RANGE_LO};
            r_rrPtr    <= '0;
            r_total    <= '0;
            r_cycles   <= '0;
            r_retired  <= '0;
         end else if (w_active) begin
            if (r_cycles != 16'hFFFF) r_cycles <= r_cycles + 16'd1;
            r_total <= w_totalSum[16] ? 16'hFFFF : w_totalSum[15:0];
            if (w_found) begin
               r_grant <= w_winOneHot;
               r_rrPtr <= PTR_W'((w_winIdx + 1) % CORES);
               if (w_exhausted) begin
                  r_grantLast <= 1'b1;
                  r_chunkLo   <= '0;
                  r_chunkHi   <= '0;
                  r_retired   <= r_retired | w_winOneHot;
               end else begin
                  r_chunkLo  <= r_nextBase[7:0];
                  r_chunkHi  <= w_chunkHi;
                  r_nextBase <= r_nextBase + 9'(CHUNK);
               end
            end
         end
      end
   end

   assign grant        = r_grant;
   assign grant_last   = r_grantLast;
   assign chunk_lo     = r_chunkLo;
   assign chunk_hi     = r_chunkHi;
   assign total_primes = r_total;
   assign clk_cycles   = r_cycles;
   assign retired      = r_retired;

endmodule

// File: tb/tb_work_dispatcher.sv
// ---------------------------------------------------------------------------
// tb_work_dispatcher
//
// Self-checking bench for work_dispatcher. The main instance uses the
// default parameters. A second single-core instance searches the range
// 0..99, which exercises the partial final chunk.
// ---------------------------------------------------------------------------
module tb_work_dispatcher;

   logic        clk = 1'b0;
   logic        reset;

   logic        start;
   logic [3:0]  req;
   logic [3:0]  grant;
   logic        grantLast;
   logic [7:0]  chunkLo;
   logic [7:0]  chunkHi;
   logic [3:0]  resValid;
   logic [31:0] resData;
   logic [15:0] totalPrimes;
   logic [15:0] clkCycles;
   logic        busy;
   logic        done;
   logic [3:0]  retired;

   logic        startB;
   logic [0:0]  reqB;
   logic [0:0]  grantB;
   logic        grantLastB;
   logic [7:0]  chunkLoB;
   logic [7:0]  chunkHiB;
   logic [0:0]  resValidB;
   logic [7:0]  resDataB;
   logic [15:0] totalPrimesB;
   logic [15:0] clkCyclesB;
   logic        busyB;
   logic        doneB;
   logic [0:0]  retiredB;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [7:0] lo;
      logic [7:0] hi;
      logic       last;
   } chunk_t;

   chunk_t expQ[$];

   typedef struct {
      logic [3:0]  req;
      logic [3:0]  resValid;
      logic [31:0] resData;
      logic [3:0]  expGrant;
      logic        chkChunk;
      logic [7:0]  expLo;
      logic [7:0]  expHi;
      logic [15:0] expTotal;
   } vec_t;

   vec_t vecs[8];

   always #5 clk = ~clk;

   work_dispatcher dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .req          (req),
      .grant        (grant),
      .grant_last   (grantLast),
      .chunk_lo     (chunkLo),
      .chunk_hi     (chunkHi),
      .res_valid    (resValid),
      .res_data     (resData),
      .total_primes (totalPrimes),
      .clk_cycles   (clkCycles),
      .busy         (busy),
      .done         (done),
      .retired      (retired)
   );

   work_dispatcher #(
      .CORES    (1),
      .CHUNK    (16),
      .RANGE_LO (8'd0),
      .RANGE_HI (8'd99)
   ) dutB (
      .clk          (clk),
      .reset        (reset),
      .start        (startB),
      .req          (reqB),
      .grant        (grantB),
      .grant_last   (grantLastB),
      .chunk_lo     (chunkLoB),
      .chunk_hi     (chunkHiB),
      .res_valid    (resValidB),
      .res_data     (resDataB),
      .total_primes (totalPrimesB),
      .clk_cycles   (clkCyclesB),
      .busy         (busyB),
      .done         (doneB),
      .retired      (retiredB)
   );

   // Advance one clock and settle just after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic [3:0] r, input logic [3:0] rv, input logic [31:0] rd);
      req      = r;
      resValid = rv;
      resData  = rd;
      step();
   endtask

   // Pop the next expected chunk from the scoreboard and compare it with
   // the grant the DUT has just issued.
   task automatic scoreGrant(input string name, input logic [7:0] lo, input logic [7:0] hi, input logic last);
      chunk_t e;
      if (expQ.size() == 0) begin
         checkOutput({name, "_unexpected_grant"}, 32'd1, 32'd0);
      end else begin
         e = expQ.pop_front();
         checkOutput({name, "_lo"}, 32'(lo), 32'(e.lo));
         checkOutput({name, "_hi"}, 32'(hi), 32'(e.hi));
         checkOutput({name, "_last"}, 32'(last), 32'(e.last));
      end
   endtask

   task automatic resetDut();
      start    = 1'b0;
      req      = '0;
      resValid = '0;
      resData  = '0;
      startB   = 1'b0;
      reqB     = '0;
      reset    = 1'b0;
      step();
      step();
      reset    = 1'b1;
      step();
   endtask

   task automatic startRun();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   initial begin
      int     cyc;
      int     idx;
      logic [3:0]  pend;
      logic [15:0] frozen;
      logic [0:0]  prevB;

      vecs[0] = '{req:4'b1111, resValid:4'b0000, resData:32'h0, expGrant:4'b0001, chkChunk:1'b1, expLo:8'd0,  expHi:8'd15, expTotal:16'd0};
      vecs[1] = '{req:4'b1110, resValid:4'b0000, resData:32'h0, expGrant:4'b0010, chkChunk:1'b1, expLo:8'd16, expHi:8'd31, expTotal:16'd0};
      vecs[2] = '{req:4'b1110, resValid:4'b0000, resData:32'h0, expGrant:4'b0100, chkChunk:1'b1, expLo:8'd32, expHi:8'd47, expTotal:16'd0};
      vecs[3] = '{req:4'b1010, resValid:4'b0000, resData:32'h0, expGrant:4'b1000, chkChunk:1'b1, expLo:8'd48, expHi:8'd63, expTotal:16'd0};
      vecs[4] = '{req:4'b0010, resValid:4'b0000, resData:32'h0, expGrant:4'b0010, chkChunk:1'b1, expLo:8'd64, expHi:8'd79, expTotal:16'd0};
      vecs[5] = '{req:4'b0010, resValid:4'b0000, resData:32'h0, expGrant:4'b0000, chkChunk:1'b0, expLo:8'd0,  expHi:8'd0,  expTotal:16'd0};
      vecs[6] = '{req:4'b0000, resValid:4'b1111, resData:32'h05030204, expGrant:4'b0000, chkChunk:1'b0, expLo:8'd0, expHi:8'd0, expTotal:16'd14};
      vecs[7] = '{req:4'b0001, resValid:4'b0000, resData:32'h0, expGrant:4'b0001, chkChunk:1'b1, expLo:8'd80, expHi:8'd95, expTotal:16'd14};

      // Reset with every request high: outputs must be zero while reset is
      // still asserted, and nothing may be granted in IDLE afterwards.
      start    = 1'b0;
      req      = 4'b1111;
      resValid = '0;
      resData  = '0;
      startB   = 1'b0;
      reqB     = '0;
      reset    = 1'b0;
      #3;
      checkOutput("rst_grant",   32'(grant),       32'd0);
      checkOutput("rst_last",    32'(grantLast),   32'd0);
      checkOutput("rst_lo",      32'(chunkLo),     32'd0);
      checkOutput("rst_hi",      32'(chunkHi),     32'd0);
      checkOutput("rst_total",   32'(totalPrimes), 32'd0);
      checkOutput("rst_cycles",  32'(clkCycles),   32'd0);
      checkOutput("rst_busy",    32'(busy),        32'd0);
      checkOutput("rst_done",    32'(done),        32'd0);
      checkOutput("rst_retired", 32'(retired),     32'd0);
      step();
      reset = 1'b1;
      step();
      step();
      step();
      checkOutput("idle_grant", 32'(grant), 32'd0);
      checkOutput("idle_busy",  32'(busy),  32'd0);
      resValid = 4'b1111;
      resData  = 32'h01010101;
      step();
      resValid = '0;
      step();
      checkOutput("idle_res_ignored", 32'(totalPrimes), 32'd0);

      // Round-robin ordering, masking of a held request, wrap-around, and
      // one cycle with all four results arriving together.
      req = '0;
      startRun();
      checkOutput("rr_busy", 32'(busy), 32'd1);
      for (int i = 0; i < 8; i++) begin
         applyStimulus(vecs[i].req, vecs[i].resValid, vecs[i].resData);
         checkOutput($sformatf("rr%0d_grant", i), 32'(grant), 32'(vecs[i].expGrant));
         if (vecs[i].chkChunk) begin
            checkOutput($sformatf("rr%0d_lo", i), 32'(chunkLo), 32'(vecs[i].expLo));
            checkOutput($sformatf("rr%0d_hi", i), 32'(chunkHi), 32'(vecs[i].expHi));
         end
         checkOutput($sformatf("rr%0d_total", i), 32'(totalPrimes), 32'(vecs[i].expTotal));
      end

      // Full run with a behavioural core model. Each core reports one prime
      // per chunk on the cycle after its grant, and then asks for more work.
      resetDut();
      startRun();
      expQ.delete();
      for (int k = 0; k < 16; k++) expQ.push_back('{lo:8'(16*k), hi:8'(16*k+15), last:1'b0});
      for (int k = 0; k < 4; k++)  expQ.push_back('{lo:8'd0, hi:8'd0, last:1'b1});
      req  = 4'b1111;
      pend = '0;
      cyc  = 0;
      while (done !== 1'b1 && cyc < 2000) begin
         step();
         cyc++;
         resValid = '0;
         resData  = '0;
         for (int i = 0; i < 4; i++) begin
            if (pend[i]) begin
               resValid[i]       = 1'b1;
               resData[8*i +: 8] = 8'd1;
               pend[i]           = 1'b0;
               req[i]            = 1'b1;
            end
         end
         if (grant != 0) begin
            checkOutput("run_onehot", 32'($onehot(grant)), 32'd1);
            scoreGrant("run", chunkLo, chunkHi, grantLast);
            idx = 0;
            for (int i = 0; i < 4; i++) if (grant[i]) idx = i;
            req[idx] = 1'b0;
            if (!grantLast) pend[idx] = 1'b1;
         end
      end
      req      = '0;
      resValid = '0;
      resData  = '0;
      checkOutput("run_done",      32'(done),        32'd1);
      checkOutput("run_busy",      32'(busy),        32'd0);
      checkOutput("run_left",      32'(expQ.size()), 32'd0);
      checkOutput("run_total",     32'(totalPrimes), 32'd16);
      checkOutput("run_retired",   32'(retired),     32'hF);
      checkOutput("run_cycles",    32'(clkCycles),   32'(cyc));
      frozen = clkCycles;
      resValid = 4'b1111;
      resData  = 32'h01010101;
      step();
      resValid = '0;
      step();
      step();
      checkOutput("done_cycles_frozen", 32'(clkCycles),   32'(frozen));
      checkOutput("done_res_ignored",   32'(totalPrimes), 32'd16);
      checkOutput("done_hold",          32'(done),        32'd1);

      // Restart from DONE: the run state must be re-initialised.
      startRun();
      checkOutput("restart_total",   32'(totalPrimes), 32'd0);
      checkOutput("restart_retired", 32'(retired),     32'd0);
      checkOutput("restart_cycles",  32'(clkCycles),   32'd0);
      checkOutput("restart_busy",    32'(busy),        32'd1);
      checkOutput("restart_done",    32'(done),        32'd0);

      // Reset in the middle of a run: all outputs must clear at once, and
      // the next run must start from RANGE_LO again.
      req = 4'b1111;
      step();
      step();
      step();
      req = '0;
      #3;
      reset = 1'b0;
      #1;
      checkOutput("midrst_grant",   32'(grant),       32'd0);
      checkOutput("midrst_lo",      32'(chunkLo),     32'd0);
      checkOutput("midrst_hi",      32'(chunkHi),     32'd0);
      checkOutput("midrst_cycles",  32'(clkCycles),   32'd0);
      checkOutput("midrst_busy",    32'(busy),        32'd0);
      checkOutput("midrst_retired", 32'(retired),     32'd0);
      step();
      reset = 1'b1;
      step();
      startRun();
      req = 4'b0001;
      step();
      req = '0;
      checkOutput("midrst_first_grant", 32'(grant),   32'd1);
      checkOutput("midrst_first_lo",    32'(chunkLo), 32'd0);
      checkOutput("midrst_first_hi",    32'(chunkHi), 32'd15);

      // Single core searching 0..99: the seventh chunk is cut short at 99,
      // and the eighth grant retires the core.
      expQ.delete();
      for (int k = 0; k < 7; k++) expQ.push_back('{lo:8'(16*k), hi:((k == 6) ? 8'd99 : 8'(16*k+15)), last:1'b0});
      expQ.push_back('{lo:8'd0, hi:8'd0, last:1'b1});
      resValidB = '0;
      resDataB  = '0;
      startB = 1'b1;
      step();
      startB = 1'b0;
      reqB   = 1'b1;
      prevB  = 1'b0;
      cyc    = 0;
      while (doneB !== 1'b1 && cyc < 300) begin
         step();
         cyc++;
         if (grantB != 0) begin
            checkOutput("part_double_grant", 32'(grantB & prevB), 32'd0);
            scoreGrant("part", chunkLoB, chunkHiB, grantLastB);
            if (grantLastB) reqB = 1'b0;
         end
         prevB = grantB;
      end
      checkOutput("part_done",    32'(doneB),       32'd1);
      checkOutput("part_left",    32'(expQ.size()), 32'd0);
      checkOutput("part_retired", 32'(retiredB),    32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
